tl_burst_arbiter: RTL
=====================

# tl_burst_arbiter

N-to-1 TileLink channel arbiter for the crossbar that keeps a multi-beat message together. Once a master wins, the grant is held until that master's last beat has been transferred. Round-robin or fixed-priority mode is selected by parameter, and an optional output spill register breaks the ready/valid timing path. It sits inside `tl_xbar` on each channel (A/C/E toward a slave, B/D toward a master), in place of the single-beat stream arbiter.

## Interface
- `N_MASTER`, default 2: number of input streams; must be ≥1. `IDX_W = max(1, $clog2(N_MASTER))`.
- `DATA_T`, default `logic[0:0]`: channel payload type.
- `ARB_MODE`, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `OUT_REG`, default 1: 1 = 2-entry spill register on the output (full throughput, +1 cycle latency); 0 = combinational output.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `inp_data_i` in `N_MASTER`×DATA_T: per-master payload.
- `inp_valid_i` in `N_MASTER`: per-master valid.
- `inp_last_i` in `N_MASTER`: marks the final beat of a message; single-beat messages tie it high.
- `inp_ready_o` out `N_MASTER`: per-master ready.
- `oup_data_o` out DATA_T: selected payload.
- `oup_idx_o` out `IDX_W`: index of the master that sourced the current output beat.
- `oup_last_o` out 1: last flag of the current output beat.
- `oup_valid_o` out 1: output valid.
- `oup_ready_i` in 1: output ready.

## Operation
- FSM states: IDLE and LOCKED. Registers: `lock_idx`, `rr_ptr` (`IDX_W`), and the spill buffer when `OUT_REG=1`.
- **IDLE**
  - Select a winner among asserted `inp_valid_i`.
  - Round-robin: first valid index ≥ `rr_ptr`, wrapping modulo N_MASTER.
  - Priority: lowest valid index.
  - Only the winner sees `inp_ready_o` = internal ready. All other readies are 0.
- **IDLE → LOCKED**: winner is valid and either (a) handshakes a beat with `last=0`, or (b) is valid but not accepted (back-pressure). In both cases `lock_idx` ← winner.
  - Rule (b) keeps the grant stable while a beat is pending. A stream may not drop or swap data before it is accepted.
- **LOCKED**
  - Only `lock_idx` is served; all other readies are 0.
  - Exit to IDLE on handshake of a beat from `lock_idx` with `last=1`.
  - A non-last handshake stays in LOCKED.
- **Round-robin pointer**: `rr_ptr` ← (granted idx + 1) mod N_MASTER, updated only on a last-beat handshake. It wraps from N_MASTER−1 to 0. It is unused in priority mode.
- **Single-beat message from IDLE**: a last-beat handshake with ready high returns to (stays in) IDLE in the same cycle. The next cycle can grant a different master, giving back-to-back messages with no bubble.
- **Output path**
  - `OUT_REG=0`: the internal ready equals `oup_ready_i`, and the output fields mux directly from the granted input.
  - `OUT_REG=1`: the spill register accepts while it is not full.
- `N_MASTER=1`: degenerates to a pass-through with lock tracking. `oup_idx_o` is always 0.

## Timing
- Reset (`rst_i`=0 at a clock edge) forces:
  - state = IDLE, `rr_ptr`=0, `lock_idx`=0, spill buffer empty.
  - Hence `oup_valid_o`=0; `oup_data_o`, `oup_idx_o`, `oup_last_o` = 0.
  - `inp_ready_o`=0 while in reset.
- A reset mid-message discards the lock and any buffered beats with no partial flush.
- Latency input→output:
  - `OUT_REG=0`: 0 cycles.
  - `OUT_REG=1`: 1 cycle.
- Throughput: one beat per cycle in both modes when `oup_ready_i` is held high.
- With `OUT_REG=1`, `inp_ready_o` depends only on registered state, with no combinational path from `oup_ready_i`.
- Output handshake rule: while `oup_valid_o`=1 and `oup_ready_i`=0, `oup_data_o`, `oup_idx_o` and `oup_last_o` hold stable.
- Inputs must obey the same rule. The arbiter does not check this.
- Simultaneous events: a last-beat handshake and new requests in the same cycle are arbitrated in the following cycle using the updated `rr_ptr`.

## Test plan
- **Round-robin fairness**: N=4, ARB_MODE=0, all valid, every message single-beat, ready=1 → `oup_idx_o` sequence 0,1,2,3,0,… with one beat per cycle (OUT_REG=1: first output in cycle 1).
- **Burst lock**: master 1 sends 4 beats (last on beat 4) while master 0 stays valid → output idx 1,1,1,1 then 0. `inp_ready_o[0]`=0 for all 4 cycles.
- **Fixed priority**: ARB_MODE=1, masters 2 and 3 valid with single beats, master 0 asserts valid at cycle 3 → master 0 wins at the next free grant. Master 3 is served only after 0 and 2 are idle.
- **Back-pressure stability**: OUT_REG=0, `oup_ready_i`=0 for 5 cycles with masters 0 and 1 valid → data and idx constant across all 5 cycles. The same beat is accepted once when ready rises.
- **Spill register**: OUT_REG=1, toggle `oup_ready_i` 1,0,1,0 with continuous 8-beat input → all 8 beats delivered in order, none dropped or duplicated. `inp_ready_o` never depends combinationally on `oup_ready_i`.
- **Reset mid-burst**: assert `rst_i`=0 after beat 2 of a 4-beat burst → next cycle `oup_valid_o`=0, state IDLE, `rr_ptr`=0. After release, a new request from master 2 is granted immediately.

Source files
------------

// File: rtl/tl_burst_arbiter.sv
// N-to-1 TileLink channel arbiter that keeps a multi-beat message together:
// the winning master holds the grant until its last beat is transferred.
module tl_burst_arbiter #(
    parameter int unsigned  N_MASTER = 2,
    parameter type          DATA_T   = logic [0:0],
    parameter int unsigned  ARB_MODE = 0,
    parameter int unsigned  OUT_REG  = 1,
    localparam int unsigned IDX_W    = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  DATA_T [N_MASTER-1:0]      inp_data_i,
    input  logic  [N_MASTER-1:0]      inp_valid_i,
    input  logic  [N_MASTER-1:0]      inp_last_i,
    output logic  [N_MASTER-1:0]      inp_ready_o,
    output DATA_T                     oup_data_o,
    output logic  [IDX_W-1:0]         oup_idx_o,
    output logic                      oup_last_o,
    output logic                      oup_valid_o,
    input  logic                      oup_ready_i
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] arb_idx, sel_idx, rr_next;
    logic             arb_found, sel_live, sel_valid, sel_ready, sel_hs;

    // Winner search: rotate from rr_ptr in round-robin mode, from 0 in priority mode.
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        arb_idx   = '0;
        arb_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < N_MASTER; k++) begin
            cand     = (ARB_MODE == 0) ? (32'(rr_ptr_q) + k) % N_MASTER : k;
            cand_idx = IDX_W'(cand);
            if (!arb_found && inp_valid_i[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    assign sel_idx   = (state_q == LOCKED) ? lock_idx_q : arb_idx;
    assign sel_live  = (state_q == LOCKED) || arb_found;
    assign sel_valid = rst_i && ((state_q == LOCKED) ? inp_valid_i[lock_idx_q] : arb_found);
    assign sel_hs    = sel_valid && sel_ready;
    assign rr_next   = IDX_W'((32'(sel_idx) + 32'd1) % N_MASTER);

    always_comb begin
        inp_ready_o = '0;
        for (int unsigned i = 0; i < N_MASTER; i++) begin
            inp_ready_o[i] = rst_i && sel_live && sel_ready && (sel_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // A pending (unaccepted) beat also locks, so the grant cannot move under it.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    if (sel_hs && inp_last_i[sel_idx]) begin
                        rr_ptr_d = rr_next;
                    end else begin
                        state_d    = LOCKED;
                        lock_idx_d = sel_idx;
                    end
                end
            end
            LOCKED: begin
                if (sel_hs && inp_last_i[sel_idx]) begin
                    state_d  = IDLE;
                    rr_ptr_d = rr_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    if (OUT_REG != 0) begin : g_spill
        DATA_T            buf_data_q [2];
        logic [IDX_W-1:0] buf_idx_q  [2];
        logic [1:0]       buf_last_q;
        logic             wr_ptr_q, rd_ptr_q;
        logic [1:0]       cnt_q, cnt_d;
        logic             push, pop;

        // Ready comes from the fill level only, cutting the path from oup_ready_i.
        assign sel_ready = (cnt_q != 2'd2);
        assign push      = sel_hs;
        assign pop       = oup_valid_o && oup_ready_i;
        assign cnt_d     = cnt_q + 2'(push) - 2'(pop);

        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                for (int e = 0; e < 2; e++) begin
                    buf_data_q[e] <= '0;
                    buf_idx_q[e]  <= '0;
                end
                buf_last_q <= '0;
                wr_ptr_q   <= 1'b0;
                rd_ptr_q   <= 1'b0;
                cnt_q      <= '0;
            end else begin
                if (push) begin
                    buf_data_q[wr_ptr_q] <= inp_data_i[sel_idx];
                    buf_idx_q[wr_ptr_q]  <= sel_idx;
                    buf_last_q[wr_ptr_q] <= inp_last_i[sel_idx];
                    wr_ptr_q             <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                cnt_q <= cnt_d;
            end
        end

        assign oup_valid_o = (cnt_q != 2'd0);
        assign oup_data_o  = buf_data_q[rd_ptr_q];
        assign oup_idx_o   = buf_idx_q[rd_ptr_q];
        assign oup_last_o  = buf_last_q[rd_ptr_q];
    end else begin : g_comb
        assign sel_ready   = oup_ready_i;
        assign oup_valid_o = sel_valid;
        assign oup_data_o  = sel_valid ? inp_data_i[sel_idx] : '0;
        assign oup_idx_o   = sel_valid ? sel_idx : '0;
        assign oup_last_o  = sel_valid && inp_last_i[sel_idx];
    end

endmodule
